seq_shift_unit: RTL and testbench

Parametrised multi-cycle shifter for the signed ALU. It generalises the fixed 1-bit A/B shift path to a variable shift amount, five shift modes and a carry-out bit. The block shifts STEP bits per cycle under a valid/ready handshake, so wide shift amounts take several cycles without adding a barrel-shifter critical path. It sits beside the arithmetic and logic units and presents a registered result with a done flag to the ALU output mux.

---
 rtl/seq_shift_unit.sv | 151 +++++++++++++++
 tb/tb_seq_shift_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: shifts up to STEP bits per cycle under a valid/ready handshake.
// States: IDLE (accepting) | SHIFT (stepping) | DONE (holding result until out_ready).
module seq_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [2:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     result,
  output logic               err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [2:0] M_SRL = 3'd0;
  localparam logic [2:0] M_SLL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROR = 3'd3;
  localparam logic [2:0] M_ROL = 3'd4;
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_work;
  logic [2:0]          r_mode;
  logic [SHAMT_W-1:0]  r_rem;
  logic [WIDTH:0]      r_result;
  logic                r_err;
  logic                r_out_valid;

  logic                w_illegal, w_accept, w_last;
  logic [SHAMT_W-1:0]  w_step, w_ridx, w_lidx;
  logic [WIDTH-1:0]    w_data_nxt;
  logic                w_carry_nxt;

  assign w_illegal = (mode > M_ROL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_state_nxt = (w_illegal || shamt == '0) ? S_DONE : S_SHIFT;
        S_SHIFT: if (w_last) w_state_nxt = S_DONE;
        S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
    w_accept = (r_state == S_IDLE) && in_valid && !clear;
    w_last   = (r_state == S_SHIFT) && (w_step == r_rem);
  end

  // One step of at most STEP bits; the carry is the last bit pushed past the boundary.
  always_comb begin
    w_step      = (r_rem > STEP_C) ? STEP_C : r_rem;
    w_ridx      = w_step - SHAMT_W'(1);
    w_lidx      = SHAMT_W'(WIDTH) - w_step;
    w_data_nxt  = r_work;
    w_carry_nxt = 1'b0;
    case (r_mode)
      M_SRL: begin
        w_data_nxt  = r_work >> w_step;
        w_carry_nxt = r_work[w_ridx];
      end
      M_SLL: begin
        w_data_nxt  = r_work << w_step;
        w_carry_nxt = r_work[w_lidx];
      end
      M_SRA: begin
        w_data_nxt  = $signed(r_work) >>> w_step;
        w_carry_nxt = r_work[w_ridx];
      end
      M_ROR: begin
        w_data_nxt  = (r_work >> w_step) | (r_work << w_lidx);
        w_carry_nxt = r_work[w_ridx];
      end
      M_ROL: begin
        w_data_nxt  = (r_work << w_step) | (r_work >> w_lidx);
        w_carry_nxt = r_work[w_lidx];
      end
      default: begin
        w_data_nxt  = r_work;
        w_carry_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work      <= '0;
      r_mode      <= '0;
      r_rem       <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_rem       <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_work <= operand;
      r_mode <= mode;
      r_rem  <= shamt;
      if (w_illegal) begin
        r_result    <= '0;
        r_err       <= 1'b1;
        r_out_valid <= 1'b1;
      end else if (shamt == '0) begin
        r_result    <= {1'b0, operand};
        r_err       <= 1'b0;
        r_out_valid <= 1'b1;
      end else begin
        r_err <= 1'b0;
      end
    end else if (r_state == S_SHIFT) begin
      r_work <= w_data_nxt;
      r_rem  <= r_rem - w_step;
      if (w_last) begin
        r_result    <= {w_carry_nxt, w_data_nxt};
        r_out_valid <= 1'b1;
      end
    end else if (r_state == S_DONE && out_ready) begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: one instance with STEP=1 and one with STEP=4.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        rst, clear, out_ready;
  logic [15:0] operand;
  logic [3:0]  shamt;
  logic [2:0]  mode;
  logic        iv1, iv4, ir1, ir4, ov1, ov4, err1, err4;
  logic [16:0] res1, res4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv1), .in_ready(ir1),
    .operand(operand), .shamt(shamt), .mode(mode), .out_valid(ov1),
    .out_ready(out_ready), .result(res1), .err(err1)
  );

  seq_shift_unit #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(iv4), .in_ready(ir4),
    .operand(operand), .shamt(shamt), .mode(mode), .out_valid(ov4),
    .out_ready(out_ready), .result(res4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input bit sel, input string tag, input logic [2:0] m,
                        input logic [15:0] op, input logic [3:0] sa,
                        input logic [16:0] exp_res, input logic exp_err, input int exp_lat);
    int n;
    @(posedge clk); #1;
    mode = m; operand = op; shamt = sa;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv4 = 1'b0;
    operand = 16'hDEAD; shamt = 4'hF; mode = 3'd1;
    n = 0;
    while (!(sel ? ov4 : ov1) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, sel ? res4 : res1, exp_res);
    check({tag, "_err"}, sel ? err4 : err1, exp_err);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy"}, sel ? ir4 : ir1, 1);
    check({tag, "_ovl"}, sel ? ov4 : ov1, 0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; out_ready = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0; operand = '0; shamt = '0; mode = '0;
    #12;
    check("rst_ov", ov1, 0);
    check("rst_res", res1, 0);
    check("rst_err", err4, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", ir1, 1);

    run_op(0, "sra",  3'd2, 16'h8004, 4'd2,  17'h0E001, 1'b0, 2);
    run_op(0, "sll",  3'd1, 16'h8001, 4'd1,  17'h10002, 1'b0, 1);
    run_op(0, "rol",  3'd4, 16'h8000, 4'd1,  17'h10001, 1'b0, 1);
    run_op(0, "ror",  3'd3, 16'h00F8, 4'd4,  17'h1800F, 1'b0, 4);
    run_op(1, "srl4", 3'd0, 16'hF0F0, 4'd15, 17'h10001, 1'b0, 4);
    run_op(1, "sra4", 3'd2, 16'h8000, 4'd5,  17'h0FC00, 1'b0, 2);
    run_op(1, "sll4", 3'd1, 16'h0F01, 4'd6,  17'h1C040, 1'b0, 2);
    run_op(0, "zero", 3'd0, 16'h1234, 4'd0,  17'h01234, 1'b0, 0);
    run_op(0, "ill7", 3'd7, 16'h1234, 4'd3,  17'h00000, 1'b1, 0);
    run_op(1, "ill5", 3'd5, 16'hFFFF, 4'd1,  17'h00000, 1'b1, 0);

    // Hold the result under back-pressure while the request side is noisy.
    @(posedge clk); #1;
    mode = 3'd0; operand = 16'h00F0; shamt = 4'd1; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    check("hold_ov0", ov1, 1);
    for (int i = 0; i < 3; i++) begin
      iv1 = (i % 2 == 0);
      operand = 16'(i * 4321 + 7);
      shamt = 4'd0;
      @(posedge clk); #1;
      check("hold_res", res1, 17'h00078);
      check("hold_rdy", ir1, 0);
      check("hold_ov", ov1, 1);
    end
    iv1 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_rdy", ir1, 1);
    check("rel_ov", ov1, 0);
    @(posedge clk); #1;
    check("rel_noacc", ov1, 0);

    // Asynchronous reset in the middle of a shift.
    mode = 3'd1; operand = 16'h0001; shamt = 4'd10; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", ir1, 0);
    rst = 1'b0;
    #1;
    check("arst_ov", ov1, 0);
    check("arst_res", res1, 0);
    check("arst_rdy", ir1, 1);
    #1 rst = 1'b1;
    run_op(0, "post_rst", 3'd1, 16'h2003, 4'd3, 17'h10018, 1'b0, 3);

    // Synchronous clear in the middle of a shift.
    @(posedge clk); #1;
    mode = 3'd1; operand = 16'h0001; shamt = 4'd10; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    #1;
    check("clr_sync", res1, 17'h10018);
    check("clr_busy", ir1, 0);
    @(posedge clk); #1;
    check("clr_ov", ov1, 0);
    check("clr_res", res1, 0);
    check("clr_rdy", ir1, 1);
    iv1 = 1'b1; mode = 3'd0; shamt = 4'd0; operand = 16'h5555;
    @(posedge clk); #1;
    check("clr_noacc_ov", ov1, 0);
    check("clr_noacc_rdy", ir1, 1);
    clear = 1'b0; iv1 = 1'b0;
    run_op(0, "post_clr", 3'd1, 16'h8001, 4'd1, 17'h10002, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
